// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_detector_param                                           |
// | Description : Serial W-bit symbol-sequence detector with overlap fallback, |
// |               input qualification, sticky mode and saturating match count. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int            W       = 2,
  parameter int            N       = 3,
  parameter logic [N*W-1:0] PATTERN = {2'd3, 2'd2, 2'd1},
  parameter int            STICKY  = 1,
  parameter int            CNT_W   = 8,
  localparam int           PW      = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     num,
  input  logic             clr,
  output logic             ans,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PW-1:0]    progress
);

  // Bit [p*(N+1)+k] is set when a k-symbol prefix can follow state p given that
  // the new symbol equals pattern symbol k-1: the first k-1 pattern symbols must
  // equal the last k-1 symbols already matched in state p.
  function automatic logic [(N+1)*(N+1)-1:0] f_border_ok();
    logic [(N+1)*(N+1)-1:0] t;
    logic                   eq;
    t = '0;
    for (int p = 0; p <= N; p++) begin
      for (int k = 1; k <= N; k++) begin
        if (k - 1 <= p) begin
          eq = 1'b1;
          for (int j = 0; j < k - 1; j++) begin
            if (PATTERN[j*W +: W] != PATTERN[(p-k+1+j)*W +: W]) eq = 1'b0;
          end
          t[p*(N+1)+k] = eq;
        end
      end
    end
    return t;
  endfunction

  localparam logic [(N+1)*(N+1)-1:0] c_border_ok = f_border_ok();
  localparam logic [PW-1:0]          c_full      = PW'(N);

  logic [PW-1:0]    r_progress;
  logic             r_match_pulse;
  logic [CNT_W-1:0] r_match_cnt;
  logic [N:1]       w_sym_hit;
  logic [PW-1:0]    w_delta;
  logic             w_absorb;
  logic             w_complete;

  genvar gk;
  generate
    for (gk = 1; gk <= N; gk++) begin : g_sym_hit
      assign w_sym_hit[gk] = (num == PATTERN[(gk-1)*W +: W]);
    end
  endgenerate

  // Largest admissible prefix wins; out-of-range states select no row and fall to 0.
  always_comb begin
    w_delta = '0;
    for (int p = 0; p <= N; p++) begin
      if (r_progress == PW'(p)) begin
        for (int k = 1; k <= N; k++) begin
          if (c_border_ok[p*(N+1)+k] && w_sym_hit[k]) w_delta = PW'(k);
        end
      end
    end
  end

  assign w_absorb   = (STICKY != 0) && (r_progress == c_full);
  assign w_complete = in_valid && !clr && !w_absorb && (w_delta == c_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_progress    <= '0;
      r_match_pulse <= 1'b0;
      r_match_cnt   <= '0;
    end else if (clr) begin
      r_progress    <= '0;
      r_match_pulse <= 1'b0;
      r_match_cnt   <= '0;
    end else begin
      r_match_pulse <= w_complete;
      if (in_valid && !w_absorb) r_progress <= w_delta;
      if (w_complete && !(&r_match_cnt)) r_match_cnt <= r_match_cnt + 1'b1;
    end
  end

  assign ans         = (r_progress == c_full);
  assign match_pulse = r_match_pulse;
  assign match_cnt   = r_match_cnt;
  assign progress    = r_progress;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_detector_param                                        |
// | Description : Directed self-checking bench for seq_detector_param.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_detector_param;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] num;
  logic       clr;

  // default instance: pattern 1,2,3 sticky
  logic       a_ans, a_pulse;
  logic [7:0] a_cnt;
  logic [1:0] a_prog;
  // pattern 1,1,1 retriggerable
  logic       b_ans, b_pulse;
  logic [7:0] b_cnt;
  logic [1:0] b_prog;
  // pattern 1,2,3 retriggerable, 2-bit counter
  logic       c_ans, c_pulse;
  logic [1:0] c_cnt;
  logic [1:0] c_prog;

  int n_checks = 0;
  int n_errors = 0;

  seq_detector_param u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .clr(clr),
    .ans(a_ans), .match_pulse(a_pulse), .match_cnt(a_cnt), .progress(a_prog)
  );

  seq_detector_param #(.STICKY(0), .PATTERN({2'd1, 2'd1, 2'd1})) u_rep (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .clr(clr),
    .ans(b_ans), .match_pulse(b_pulse), .match_cnt(b_cnt), .progress(b_prog)
  );

  seq_detector_param #(.STICKY(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .clr(clr),
    .ans(c_ans), .match_pulse(c_pulse), .match_cnt(c_cnt), .progress(c_prog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] n, input logic c);
    in_valid = v;
    num      = n;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    step(1'b0, 2'd0, 1'b1);
  endtask

  initial begin
    logic [1:0] seq[5];
    int         exp_prog[5];

    rst_n = 1'b0; in_valid = 1'b0; num = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prog", int'(a_prog), 0);
    chk("rst_ans", int'(a_ans), 0);
    chk("rst_pulse", int'(a_pulse), 0);
    chk("rst_cnt", int'(a_cnt), 0);
    rst_n = 1'b1;

    // 1: basic match then sticky hold
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t1_prog%0d", i), int'(a_prog), (i < 2) ? i + 1 : 3);
      chk($sformatf("t1_ans%0d", i), int'(a_ans), (i >= 2) ? 1 : 0);
      chk($sformatf("t1_pulse%0d", i), int'(a_pulse), (i == 2) ? 1 : 0);
    end
    chk("t1_cnt", int'(a_cnt), 1);

    // 2: fallback on partial prefix
    clear();
    chk("t2_clr_prog", int'(a_prog), 0);
    chk("t2_clr_cnt", int'(a_cnt), 0);
    seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    exp_prog = '{1, 2, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t2a_prog%0d", i), int'(a_prog), exp_prog[i]);
    end
    chk("t2a_ans", int'(a_ans), 1);
    clear();
    seq = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_prog = '{1, 1, 2, 3, 3};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t2b_prog%0d", i), int'(a_prog), exp_prog[i]);
      chk($sformatf("t2b_ans%0d", i), int'(a_ans), (i == 3) ? 1 : 0);
    end

    // 3: overlapping matches with pattern 1,1,1
    clear();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd1, 1'b0);
      chk($sformatf("t3_prog%0d", i), int'(b_prog), (i < 2) ? i + 1 : 3);
      chk($sformatf("t3_pulse%0d", i), int'(b_pulse), (i >= 2) ? 1 : 0);
    end
    chk("t3_cnt", int'(b_cnt), 3);
    step(1'b1, 2'd0, 1'b0);
    chk("t3_break_prog", int'(b_prog), 0);
    chk("t3_break_ans", int'(b_ans), 0);
    chk("t3_break_pulse", int'(b_pulse), 0);

    // 4: invalid cycles hold state and ignore num
    clear();
    step(1'b1, 2'd1, 1'b0); chk("t4_prog0", int'(a_prog), 1);
    step(1'b0, 2'd3, 1'b0); chk("t4_gap0", int'(a_prog), 1);
    chk("t4_gap0_ans", int'(a_ans), 0);
    step(1'b1, 2'd2, 1'b0); chk("t4_prog1", int'(a_prog), 2);
    step(1'b0, 2'd0, 1'b0); chk("t4_gap1", int'(a_prog), 2);
    step(1'b1, 2'd3, 1'b0); chk("t4_prog2", int'(a_prog), 3);
    chk("t4_pulse", int'(a_pulse), 1);
    chk("t4_cnt", int'(a_cnt), 1);
    step(1'b0, 2'd0, 1'b0); chk("t4_pulse_end", int'(a_pulse), 0);

    // 5: asynchronous reset between edges
    clear();
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    chk("t5_pre_prog", int'(a_prog), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_prog", int'(a_prog), 0);
    chk("t5_async_ans", int'(a_ans), 0);
    chk("t5_async_cnt", int'(a_cnt), 0);
    #2 rst_n = 1'b1;
    step(1'b1, 2'd3, 1'b0);
    chk("t5_after_prog", int'(a_prog), 0);
    chk("t5_after_ans", int'(a_ans), 0);
    chk("t5_after_pulse", int'(a_pulse), 0);

    // 6: counter saturation, then clr beats in_valid
    clear();
    for (int m = 0; m < 5; m++) begin
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd3, 1'b0);
      chk($sformatf("t6_cnt%0d", m), int'(c_cnt), (m < 3) ? m + 1 : 3);
      chk($sformatf("t6_pulse%0d", m), int'(c_pulse), 1);
    end
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    chk("t6_pre_clr_prog", int'(c_prog), 2);
    step(1'b1, 2'd3, 1'b1);
    chk("t6_clr_prog", int'(c_prog), 0);
    chk("t6_clr_cnt", int'(c_cnt), 0);
    chk("t6_clr_pulse", int'(c_pulse), 0);
    chk("t6_clr_ans", int'(c_ans), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
